// File: rtl/pipe_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory port, hazard/redirect controls,
// IF/ID outputs and RAS status flags. The fetch unit uses the master
// modport and the surrounding CPU or testbench uses the slave modport.
// When FETCH_STATS_EN is defined, the bus also carries the stall and
// redirect statistics counters.
interface pipe_fetch_unit_if #(
  parameter int unsigned PC_W  = 12,
  parameter int unsigned INS_W = 19,
  parameter int unsigned OFF_W = 8
);
  logic [PC_W-1:0]  imem_addr;
  logic [INS_W-1:0] imem_data;
  logic             stall;
  logic             flush;
  logic [1:0]       pc_src;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  branch_base;
  logic [OFF_W-1:0] branch_off;
  logic             call;
  logic [PC_W-1:0]  ifid_pc;
  logic [INS_W-1:0] ifid_ins;
  logic             ifid_valid;
  logic             ras_overflow;
  logic             ras_underflow;
`ifdef FETCH_STATS_EN
  logic [15:0]      stall_cycles;
  logic [15:0]      redirect_count;
`endif

  // Fetch-unit side
  modport master (
`ifdef FETCH_STATS_EN
    output stall_cycles,
    output redirect_count,
`endif
    output imem_addr,
    input  imem_data,
    input  stall,
    input  flush,
    input  pc_src,
    input  target,
    input  branch_base,
    input  branch_off,
    input  call,
    output ifid_pc,
    output ifid_ins,
    output ifid_valid,
    output ras_overflow,
    output ras_underflow
  );

  // CPU / memory side
  modport slave (
`ifdef FETCH_STATS_EN
    input  stall_cycles,
    input  redirect_count,
`endif
    input  imem_addr,
    output imem_data,
    output stall,
    output flush,
    output pc_src,
    output target,
    output branch_base,
    output branch_off,
    output call,
    input  ifid_pc,
    input  ifid_ins,
    input  ifid_valid,
    input  ras_overflow,
    input  ras_underflow
  );
endinterface

// File: rtl/pipe_fetch_unit.sv
// Instruction-fetch front end: PC register, next-PC selection (sequential,
// jump, return, PC-relative branch), a circular return-address stack and
// the IF/ID pipeline register with stall/flush/valid tracking.
// Optional statistics counters are enabled by defining FETCH_STATS_EN.
module pipe_fetch_unit #(
  parameter int unsigned     PC_W      = 12,
  parameter int unsigned     INS_W     = 19,
  parameter int unsigned     OFF_W     = 8,
  parameter int unsigned     RAS_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst,
  pipe_fetch_unit_if.master  bus
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] SRC_SEQ  = 2'b00;
  localparam logic [1:0] SRC_JUMP = 2'b01;
  localparam logic [1:0] SRC_RET  = 2'b10;
  localparam logic [1:0] SRC_BR   = 2'b11;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [PC_W-1:0]  ras_d [RAS_DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [PC_W-1:0]  ifid_pc_q, ifid_pc_d;
  logic [INS_W-1:0] ifid_ins_q, ifid_ins_d;
  logic             ifid_valid_q, ifid_valid_d;

  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  off_sext;
  logic [PTR_W-1:0] top_idx;
  logic             ras_full;
  logic             ras_empty;

  assign pc_inc    = pc_q + PC_W'(1);
  assign off_sext  = PC_W'($signed(bus.branch_off));
  assign top_idx   = sp_q - PTR_W'(1);
  assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
  assign ras_empty = (cnt_q == '0);

  // Next-PC selection and return-stack update.
  // sp_q is the next free slot; once the stack is full it also points at the
  // oldest entry, so a push while full overwrites that entry.
  always_comb begin
    pc_d  = pc_q;
    ras_d = ras_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    case (bus.pc_src)
      SRC_SEQ: begin
        if (!bus.stall) pc_d = pc_inc;
      end
      SRC_JUMP: begin
        pc_d = bus.target;
        if (bus.call) begin
          ras_d[sp_q] = bus.branch_base;
          sp_d        = sp_q + PTR_W'(1);
          if (ras_full) ovf_d = 1'b1;
          else          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SRC_RET: begin
        if (ras_empty) begin
          pc_d  = RESET_PC;
          unf_d = 1'b1;
        end else begin
          pc_d  = ras_q[top_idx];
          sp_d  = top_idx;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SRC_BR: begin
        pc_d = bus.branch_base + off_sext;
      end
      default: pc_d = pc_q;
    endcase
  end

  // IF/ID register: flush beats stall, and stall holds the register.
  always_comb begin
    ifid_pc_d    = ifid_pc_q;
    ifid_ins_d   = ifid_ins_q;
    ifid_valid_d = ifid_valid_q;
    if (bus.flush) begin
      ifid_pc_d    = '0;
      ifid_ins_d   = '0;
      ifid_valid_d = 1'b0;
    end else if (!bus.stall) begin
      ifid_pc_d    = pc_inc;
      ifid_ins_d   = bus.imem_data;
      ifid_valid_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      sp_q         <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_ins_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ras_q        <= ras_d;
      sp_q         <= sp_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_ins_q   <= ifid_ins_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign bus.imem_addr     = pc_q;
  assign bus.ifid_pc       = ifid_pc_q;
  assign bus.ifid_ins      = ifid_ins_q;
  assign bus.ifid_valid    = ifid_valid_q;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;

`ifdef FETCH_STATS_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] redirect_count_q, redirect_count_d;

  // Saturating statistics counters.
  always_comb begin
    stall_cycles_d   = stall_cycles_q;
    redirect_count_d = redirect_count_q;
    if (bus.stall && (bus.pc_src == SRC_SEQ) && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 16'd1;
    if ((bus.pc_src != SRC_SEQ) && (redirect_count_q != '1))
      redirect_count_d = redirect_count_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q   <= '0;
      redirect_count_q <= '0;
    end else begin
      stall_cycles_q   <= stall_cycles_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign bus.stall_cycles   = stall_cycles_q;
  assign bus.redirect_count = redirect_count_q;
`endif

endmodule
